stream_demux_n: RTL and testbench
=================================

Name: stream_demux_n

Overview:
- Parametrised 1-to-N stream demultiplexer. Successor to the combinational 4-way demux in the lab datapath.
- Routes one input word to a selected output channel, or to all channels in broadcast mode.
- Uses a valid/ready handshake with one register slot per output channel, so each output stalls independently.
- Sits between a single producer and N downstream consumers in the lab datapath.

Parameters:
- N_OUT, 4, number of output channels (2..16; need not be a power of two).
- DATA_W, 8, payload width in bits.
- SEL_W, $clog2(N_OUT), select width. Derived; not overridden by users.
- CNT_W, 8, width of the saturating drop counter.

Ports:
- clk  input  1  rising-edge clock.
- rst  input  1  synchronous, active-high reset.
- in_valid  input  1  producer has a word.
- in_ready  output  1  block accepts the word this cycle.
- in_data  input  DATA_W  payload.
- in_sel  input  SEL_W  destination channel index.
- in_bcast  input  1  1 = copy the word to every channel; in_sel is ignored.
- out_valid  output  N_OUT  per-channel slot full.
- out_ready  input  N_OUT  per-channel consumer accepts.
- out_data  output  N_OUT*DATA_W  channel k occupies bits [k*DATA_W +: DATA_W].
- sel_err  output  1  one-cycle pulse: an out-of-range in_sel word was accepted and dropped.
- drop_cnt  output  CNT_W  saturating count of dropped words.

Behaviour:
- Reset (synchronous, rst=1 at a rising edge):
  - out_valid=0, out_data=0, sel_err=0, drop_cnt=0.
  - Any pending slot contents are discarded.
  - in_ready is 0 while rst=1.
- Slot k "can load" when out_valid[k]=0, or out_valid[k]=1 with out_ready[k]=1 (drain and refill in the same cycle).
- in_ready is combinational:
  - Unicast, in_sel<N_OUT: in_ready = can_load[in_sel].
  - Broadcast: in_ready = AND of can_load over all k.
  - Unicast, in_sel>=N_OUT: in_ready = 1.
  - in_ready depends on out_ready combinationally. This path is accepted by design.
- Accept = in_valid & in_ready.
  - Unicast accept: slot in_sel loads in_data and sets out_valid at the same edge.
  - Broadcast accept: all slots load in_data and set out_valid.
- Latency: a word accepted at edge t is visible on out_data/out_valid after edge t (1 cycle).
- Full throughput: one word per cycle per channel while the consumer holds out_ready=1.
- Drain: out_valid[k]&out_ready[k] clears out_valid[k] at the edge, unless slot k reloads in the same cycle, in which case it stays 1 with the new data.
- Stability: while out_valid[k]=1 and out_ready[k]=0, out_data[k] and out_valid[k] hold.
- Out-of-range select (only possible when N_OUT is not a power of two):
  - The word is accepted and discarded.
  - sel_err=1 for exactly the following cycle.
  - drop_cnt increments, saturating at 2^CNT_W-1.
  - Broadcast never raises sel_err.
- Channels are independent. A stall on channel j never blocks a unicast to channel k≠j, but does block broadcast.
- in_valid=0: no state change except drains. sel_err deasserts.
- Data is taken only on accept. in_data, in_sel and in_bcast are don't-care otherwise.
- Reset mid-operation: all held words are lost and no drop is counted. Operation resumes on the first cycle after rst falls.

Decomposition:
- Shared package: demux_pkg. Holds the default N_OUT/DATA_W constants and the slot-index helper function, which checks range against N_OUT.
- Sub-module: demux_slot (one per channel, generate loop).
  - Inputs: load, load_data, out_ready.
  - Outputs: can_load, out_valid, out_data.
- Top level holds the select decode, the in_ready reduction, sel_err and drop_cnt.

Test Plan:
1. Reset, then unicast sweep. Stimulus: rst 2 cycles; then in_sel=0,1,2,3 with in_data=A0,A1,A2,A3, in_valid=1, out_ready=4'b1111. Required: each word appears on its channel 1 cycle after accept, one word per cycle; no other out_valid bit asserts.
2. Per-channel backpressure. Stimulus: out_ready[2]=0; send in_sel=2 data 55, then in_sel=2 data 66, then in_sel=1 data 77. Required:
   - 55 is held on channel 2 and out_valid[2] stays 1.
   - in_ready=0 for the 66 word.
   - The 77 word is accepted and appears on channel 1 regardless of the channel 2 stall.
   - Raising out_ready[2] drains 55 and accepts 66 in the same cycle.
3. Broadcast. Stimulus: in_bcast=1, data C3, all out_ready=1. Required: out_valid=4'b1111, all channels = C3 after 1 cycle. Repeat with out_ready[0]=0 and slot 0 full. Required: in_ready=0 until out_ready[0]=1.
4. Out-of-range select. Stimulus: N_OUT=3, in_sel=3, data 9A, accepted 3 times. Required: no out_valid; sel_err pulses 3 times; drop_cnt=3. Also force 300 drops with CNT_W=8. Required: drop_cnt saturates at 255.
5. Reset mid-operation. Stimulus: fill all slots with out_ready=0, assert rst for 1 cycle. Required: next cycle out_valid=0, out_data=0, drop_cnt=0; the next accepted word routes normally.
6. Randomised throughput check. Stimulus: random out_ready against a scoreboard model of per-channel order. Required: no loss or duplication of any word, and order preserved on every channel.

Source files
------------

// File: rtl/demux_pkg.sv
// rtl/demux_pkg.sv - shared constants and select-range helper for stream_demux_n
//
// Contents:
//   DEF_N_OUT, DEF_DATA_W, DEF_CNT_W : default channel count, payload width, drop counter width
//   sel_in_range(sel, n_out)         : 1 when sel addresses an existing channel
package demux_pkg;

  localparam int DEF_N_OUT  = 4;
  localparam int DEF_DATA_W = 8;
  localparam int DEF_CNT_W  = 8;

  function automatic logic sel_in_range(input logic [31:0] sel, input int unsigned n_out);
    return (sel < n_out);
  endfunction

endpackage

// File: rtl/demux_slot.sv
// rtl/demux_slot.sv - one-entry output register slot with valid/ready handshake
//
// Ports:
//   clk, rst       : rising-edge clock, synchronous active-high reset
//   load           : write load_data into the slot this cycle
//   load_data      : payload to store
//   out_ready      : downstream consumer accepts the held word
//   can_load       : slot is empty or is being drained this cycle
//   out_valid      : slot holds a word
//   out_data       : held word (zero after reset)
module demux_slot #(
  parameter int DATA_W = 8
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              load,
  input  logic [DATA_W-1:0] load_data,
  input  logic              out_ready,
  output logic              can_load,
  output logic              out_valid,
  output logic [DATA_W-1:0] out_data
);

  // Drain and refill in the same cycle keeps full throughput.
  assign can_load = ~out_valid | out_ready;

  always_ff @(posedge clk) begin
    if (rst) begin
      out_valid <= 1'b0;
      out_data  <= '0;
    end else if (load) begin
      out_valid <= 1'b1;
      out_data  <= load_data;
    end else if (out_ready) begin
      // Data is left in place after a drain; only valid drops.
      out_valid <= 1'b0;
    end
  end

endmodule

// File: rtl/stream_demux_n.sv
// rtl/stream_demux_n.sv - 1-to-N stream demultiplexer with unicast/broadcast and per-channel slots
//
// Ports:
//   clk, rst               : rising-edge clock, synchronous active-high reset
//   in_valid/in_ready      : producer handshake (in_ready is combinational on out_ready)
//   in_data                : payload
//   in_sel                 : destination channel (ignored when in_bcast=1)
//   in_bcast               : copy the word to every channel
//   out_valid/out_ready    : per-channel handshake, one bit per channel
//   out_data               : channel k at [k*DATA_W +: DATA_W]
//   sel_err                : one-cycle pulse after an out-of-range word is accepted and dropped
//   drop_cnt               : saturating count of dropped words
module stream_demux_n
  import demux_pkg::*;
#(
  parameter int N_OUT  = DEF_N_OUT,
  parameter int DATA_W = DEF_DATA_W,
  parameter int SEL_W  = $clog2(N_OUT),
  parameter int CNT_W  = DEF_CNT_W
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    in_valid,
  output logic                    in_ready,
  input  logic [DATA_W-1:0]       in_data,
  input  logic [SEL_W-1:0]        in_sel,
  input  logic                    in_bcast,
  output logic [N_OUT-1:0]        out_valid,
  input  logic [N_OUT-1:0]        out_ready,
  output logic [N_OUT*DATA_W-1:0] out_data,
  output logic                    sel_err,
  output logic [CNT_W-1:0]        drop_cnt
);

  logic [N_OUT-1:0] sel_hit;
  logic [N_OUT-1:0] can_load;
  logic [N_OUT-1:0] load;
  logic             uni_ready;
  logic             accept;
  logic             drop;

  always_comb begin
    // An out-of-range select matches no channel, so it stays ready and the word is sunk.
    uni_ready = 1'b1;
    for (int k = 0; k < N_OUT; k++) begin
      if (sel_hit[k]) uni_ready = can_load[k];
    end
    if (rst)           in_ready = 1'b0;
    else if (in_bcast) in_ready = &can_load;
    else               in_ready = uni_ready;
  end

  assign accept = in_valid & in_ready;
  assign drop   = accept & ~in_bcast & ~sel_in_range(32'(in_sel), N_OUT);

  for (genvar k = 0; k < N_OUT; k++) begin : g_slot
    assign sel_hit[k] = (32'(in_sel) == k);
    assign load[k]    = accept & (in_bcast | sel_hit[k]);

    demux_slot #(.DATA_W(DATA_W)) u_slot (
      .clk       (clk),
      .rst       (rst),
      .load      (load[k]),
      .load_data (in_data),
      .out_ready (out_ready[k]),
      .can_load  (can_load[k]),
      .out_valid (out_valid[k]),
      .out_data  (out_data[k*DATA_W +: DATA_W])
    );
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      sel_err  <= 1'b0;
      drop_cnt <= '0;
    end else begin
      sel_err <= drop;
      if (drop && (drop_cnt != {CNT_W{1'b1}})) drop_cnt <= drop_cnt + CNT_W'(1);
    end
  end

endmodule

// File: tb/tb_stream_demux_n.sv
// tb/tb_stream_demux_n.sv - directed and randomised self-checking bench for stream_demux_n
module tb_stream_demux_n;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  // 4-channel instance
  logic        in_valid4 = 1'b0;
  logic        in_ready4;
  logic [7:0]  in_data4 = '0;
  logic [1:0]  in_sel4 = '0;
  logic        in_bcast4 = 1'b0;
  logic [3:0]  out_valid4;
  logic [3:0]  out_ready4 = '0;
  logic [31:0] out_data4;
  logic        sel_err4;
  logic [7:0]  drop_cnt4;

  // 3-channel instance (out-of-range select reachable)
  logic        in_valid3 = 1'b0;
  logic        in_ready3;
  logic [7:0]  in_data3 = '0;
  logic [1:0]  in_sel3 = '0;
  logic        in_bcast3 = 1'b0;
  logic [2:0]  out_valid3;
  logic [2:0]  out_ready3 = '0;
  logic [23:0] out_data3;
  logic        sel_err3;
  logic [7:0]  drop_cnt3;

  stream_demux_n #(.N_OUT(4), .DATA_W(8), .CNT_W(8)) dut4 (
    .clk(clk), .rst(rst), .in_valid(in_valid4), .in_ready(in_ready4), .in_data(in_data4),
    .in_sel(in_sel4), .in_bcast(in_bcast4), .out_valid(out_valid4), .out_ready(out_ready4),
    .out_data(out_data4), .sel_err(sel_err4), .drop_cnt(drop_cnt4)
  );

  stream_demux_n #(.N_OUT(3), .DATA_W(8), .CNT_W(8)) dut3 (
    .clk(clk), .rst(rst), .in_valid(in_valid3), .in_ready(in_ready3), .in_data(in_data3),
    .in_sel(in_sel3), .in_bcast(in_bcast3), .out_valid(out_valid3), .out_ready(out_ready3),
    .out_data(out_data3), .sel_err(sel_err3), .drop_cnt(drop_cnt3)
  );

  int n_checks = 0;
  int n_fail   = 0;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [7:0] ch4(input int k);
    return out_data4[k*8 +: 8];
  endfunction

  logic [7:0] sb [4][$];

  initial begin
    // 1. Reset, then unicast sweep
    tick();
    check("rst_in_ready", in_ready4, 0);
    check("rst_out_valid", out_valid4, 0);
    check("rst_out_data", out_data4, 0);
    check("rst_sel_err", sel_err4, 0);
    check("rst_drop_cnt", drop_cnt4, 0);
    tick();
    rst = 1'b0;
    out_ready4 = 4'b1111;
    in_valid4  = 1'b1;
    for (int i = 0; i < 4; i++) begin
      in_sel4  = 2'(i);
      in_data4 = 8'hA0 + 8'(i);
      #1;
      check("sweep_in_ready", in_ready4, 1);
      tick();
      check("sweep_valid", out_valid4, 64'(4'b0001 << i));
      check("sweep_data", ch4(i), 8'hA0 + 8'(i));
    end
    in_valid4 = 1'b0;
    tick();
    check("sweep_idle", out_valid4, 0);

    // 2. Per-channel backpressure on channel 2
    out_ready4 = 4'b1011;
    in_valid4 = 1'b1; in_sel4 = 2'd2; in_data4 = 8'h55;
    #1; check("bp_rdy55", in_ready4, 1);
    tick();
    check("bp_valid55", out_valid4, 4'b0100);
    check("bp_data55", ch4(2), 8'h55);
    in_data4 = 8'h66;
    #1; check("bp_rdy66_blocked", in_ready4, 0);
    tick();
    check("bp_hold_valid", out_valid4, 4'b0100);
    check("bp_hold_data", ch4(2), 8'h55);
    in_sel4 = 2'd1; in_data4 = 8'h77;
    #1; check("bp_rdy77", in_ready4, 1);
    tick();
    check("bp_valid77", out_valid4, 4'b0110);
    check("bp_data77", ch4(1), 8'h77);
    check("bp_still55", ch4(2), 8'h55);
    in_sel4 = 2'd2; in_data4 = 8'h66; out_ready4 = 4'b1111;
    #1; check("bp_rdy66_drain", in_ready4, 1);
    tick();
    check("bp_valid66", out_valid4, 4'b0100);
    check("bp_data66", ch4(2), 8'h66);
    in_valid4 = 1'b0;
    tick();
    check("bp_idle", out_valid4, 0);

    // 3. Broadcast
    in_valid4 = 1'b1; in_bcast4 = 1'b1; in_data4 = 8'hC3;
    #1; check("bc_rdy", in_ready4, 1);
    tick();
    in_valid4 = 1'b0;
    check("bc_valid", out_valid4, 4'b1111);
    check("bc_data", out_data4, 32'hC3C3C3C3);
    out_ready4 = 4'b1110;
    tick();
    check("bc_slot0_full", out_valid4, 4'b0001);
    in_valid4 = 1'b1; in_data4 = 8'h5A;
    #1; check("bc_blocked", in_ready4, 0);
    tick();
    check("bc_still_blocked", in_ready4, 0);
    check("bc_hold0", ch4(0), 8'hC3);
    out_ready4 = 4'b1111;
    #1; check("bc_unblocked", in_ready4, 1);
    tick();
    check("bc2_valid", out_valid4, 4'b1111);
    check("bc2_data", out_data4, 32'h5A5A5A5A);
    in_valid4 = 1'b0; in_bcast4 = 1'b0;
    tick();
    check("bc_idle", out_valid4, 0);

    // 4. Out-of-range select on the 3-channel instance
    out_ready3 = 3'b111; in_sel3 = 2'd3; in_data3 = 8'h9A;
    for (int i = 0; i < 3; i++) begin
      in_valid3 = 1'b1;
      #1; check("oor_rdy", in_ready3, 1);
      tick();
      check("oor_err_hi", sel_err3, 1);
      check("oor_no_valid", out_valid3, 0);
      in_valid3 = 1'b0;
      tick();
      check("oor_err_lo", sel_err3, 0);
    end
    check("oor_cnt3", drop_cnt3, 3);
    in_valid3 = 1'b1; in_bcast3 = 1'b1;
    tick();
    check("oor_bcast_no_err", sel_err3, 0);
    check("oor_bcast_valid", out_valid3, 3'b111);
    check("oor_bcast_data", out_data3, 24'h9A9A9A);
    in_bcast3 = 1'b0;
    for (int i = 0; i < 297; i++) tick();
    check("oor_sat", drop_cnt3, 255);
    check("oor_sat_err", sel_err3, 1);
    in_valid3 = 1'b0;
    tick();
    check("oor_sat_hold", drop_cnt3, 255);
    check("oor_sat_err_lo", sel_err3, 0);

    // 5. Reset mid-operation
    out_ready4 = 4'b0000;
    in_valid4 = 1'b1; in_bcast4 = 1'b1; in_data4 = 8'h11;
    tick();
    check("mid_full", out_valid4, 4'b1111);
    rst = 1'b1;
    #1; check("mid_rst_in_ready", in_ready4, 0);
    tick();
    rst = 1'b0; in_valid4 = 1'b0; in_bcast4 = 1'b0;
    check("mid_valid", out_valid4, 0);
    check("mid_data", out_data4, 0);
    check("mid_drop4", drop_cnt4, 0);
    check("mid_drop3", drop_cnt3, 0);
    out_ready4 = 4'b1111; in_valid4 = 1'b1; in_sel4 = 2'd3; in_data4 = 8'h3C;
    tick();
    check("mid_after_valid", out_valid4, 4'b1000);
    check("mid_after_data", ch4(3), 8'h3C);
    in_valid4 = 1'b0;
    tick();

    // 6. Randomised throughput against a per-channel order model
    for (int c = 0; c < 600; c++) begin
      logic [3:0] exp_ready_k;
      logic       exp_in_ready;
      out_ready4 = 4'($urandom);
      in_valid4  = 1'($urandom);
      in_sel4    = 2'($urandom);
      in_bcast4  = ($urandom_range(0, 7) == 0);
      in_data4   = 8'($urandom);
      #1;
      for (int k = 0; k < 4; k++) begin
        check("rnd_valid", out_valid4[k], sb[k].size() != 0);
        exp_ready_k[k] = (sb[k].size() == 0) | out_ready4[k];
      end
      exp_in_ready = in_bcast4 ? (&exp_ready_k) : exp_ready_k[in_sel4];
      check("rnd_in_ready", in_ready4, exp_in_ready);
      for (int k = 0; k < 4; k++) begin
        if (out_ready4[k] && sb[k].size() != 0) check("rnd_data", ch4(k), sb[k].pop_front());
      end
      if (in_valid4 && exp_in_ready) begin
        for (int k = 0; k < 4; k++) begin
          if (in_bcast4 || in_sel4 == 2'(k)) sb[k].push_back(in_data4);
        end
      end
      tick();
    end
    in_valid4 = 1'b0; out_ready4 = 4'b1111;
    #1;
    for (int k = 0; k < 4; k++) begin
      if (sb[k].size() != 0) check("rnd_final_data", ch4(k), sb[k].pop_front());
    end
    tick();
    check("rnd_drained", out_valid4, 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
